pps_period_ctrl: RTL and testbench
==================================

# pps_period_ctrl

Controller that sequences the PPS interval counter. It synchronises the raw PPS input and measures the number of system-clock cycles between consecutive PPS rising edges. It publishes each measurement to a shadow register read by the SPI readout path, and arbitrates between new captures and an in-progress SPI frame so the SPI never shifts a changing value. It also flags lost PPS and overwritten (unread) captures.

## Interface
Parameters:
- `CNT_W`, 24: width of the interval counter and the published count.
- `MISS_LIMIT`, 16_000_000: cycles without a PPS edge before PPS is declared lost. Must satisfy 2 ≤ `MISS_LIMIT` ≤ 2^`CNT_W`−1.

Ports:
- `mcu_clko` in 1: system clock. Single clock domain.
- `cpld_rst` in 1: reset, synchronous, active-high.
- `rxd_1v8` in 1: raw PPS, asynchronous to `mcu_clko`.
- `cnt_en` in 1: enables measurement. Synchronous to `mcu_clko`.
- `rd_lock` in 1: SPI frame active. Level, synchronous to `mcu_clko`.
- `rd_done` in 1: single-cycle pulse at the end of an SPI read.
- `pps_cnt` out `CNT_W`: last published interval, in cycles.
- `cnt_new` out 1: `pps_cnt` holds a value not yet acknowledged by `rd_done`.
- `cnt_ovr` out 1: sticky flag; a capture was overwritten or published over an unread value.
- `pps_miss` out 1: sticky flag; PPS lost.
- `ctl_state` out 2: FSM state, for debug.

## Operation
- **Input sync:** 3-flop chain s1→s2→s3 on `rxd_1v8`. `pps_rise` = s2 & ~s3, always exactly 1 cycle wide.
- **FSM states:** IDLE=00, ARM=01, RUN=10, LOST=11.
  - IDLE: `run_cnt` = 0. When `cnt_en`=1, go to ARM.
  - ARM: on `pps_rise`, go to RUN with `run_cnt` ← 0. No capture is taken, because the interval before the first edge is partial.
  - RUN:
    - Without `pps_rise`: `run_cnt` increments.
    - On `pps_rise`: capture `run_cnt`+1, then `run_cnt` ← 0. Result: edges N cycles apart capture N.
    - If `run_cnt` == `MISS_LIMIT`−1 and `pps_rise`=0: go to LOST and set `pps_miss`.
    - If an edge arrives on that same cycle, the edge wins: the capture equals `MISS_LIMIT` and the FSM stays in RUN.
  - LOST: `run_cnt` holds. On `pps_rise`, go to RUN with `run_cnt` ← 0, clear `pps_miss`, and take no capture.
  - `cnt_en`=0 in any state: next state is IDLE, `run_cnt` ← 0, and any pending capture is discarded. `pps_cnt`, `cnt_new`, `cnt_ovr` and `pps_miss` hold their values.
- **Publish and arbitration:**
  - Capture with `rd_lock`=0: `pps_cnt` ← capture and `cnt_new` ← 1 on the next edge. If `cnt_new` was already 1, also set `cnt_ovr`.
  - Capture with `rd_lock`=1: the value goes into the pending register and `pend_vld` ← 1. `pps_cnt` does not change while `rd_lock`=1.
  - If a second capture arrives while `pend_vld`=1: the pending value is overwritten with the newest capture and `cnt_ovr` is set.
  - First cycle with `rd_lock`=0 and `pend_vld`=1: publish the pending value (`pps_cnt`, `cnt_new` ← 1, `cnt_ovr` set if `cnt_new` was 1) and clear `pend_vld`.
  - A capture on the same cycle that pending drains with `rd_lock`=0: the new capture is published, and `cnt_ovr` is set.
- **`rd_done`:** clears `cnt_new` and `cnt_ovr`. If a publish happens on the same cycle, `cnt_new` ends at 1 and `cnt_ovr` ends at 0.
- **Arithmetic:** unsigned, `CNT_W` bits. No wrap is possible, because the `MISS_LIMIT` bound prevents overflow.

## Timing
- **Reset:** on the first rising edge with `cpld_rst`=1, all outputs, `run_cnt`, `pend_vld`, the pending register and the sync flops go to 0, and `ctl_state` = IDLE. Reset overrides every other input, including mid-RUN and with a pending capture.
- **PPS latency:** `rxd_1v8` is first sampled high at edge k; `pps_rise` is high between edges k+1 and k+2; `pps_cnt` and `cnt_new` update at edge k+2.
- **Deferred publish:** lands 1 edge after `rd_lock` is first sampled low.
- **State transitions** take effect on the edge following the qualifying condition.
- **LOST entry:** `pps_miss` rises `MISS_LIMIT` cycles after the last accepted `pps_rise`.

## Test plan
- **Reset:** hold `cpld_rst` 2 cycles with PPS toggling → all outputs 0, `ctl_state`=00. Assert `cpld_rst` mid-RUN with `pend_vld`=1 → everything cleared; the next publish does not use the stale pending value.
- **Basic measurement:** `MISS_LIMIT`=100, `cnt_en`=1, `pps_rise` every 50 cycles → first edge gives no publish. Second edge gives `pps_cnt`=50 and `cnt_new`=1 at that edge+1. `rd_done` → `cnt_new`=0.
- **Deferral:** `rd_lock`=1 across the capture edge → `pps_cnt` stays at its old value. One edge after `rd_lock` falls → `pps_cnt`=50, `cnt_new`=1. Two captures inside one lock window (periods 50 then 40) → `pps_cnt`=40 and `cnt_ovr`=1.
- **Overrun:** two captures with no `rd_done` → `cnt_ovr`=1. `rd_done` coinciding with a publish → `cnt_new`=1, `cnt_ovr`=0.
- **Loss:** `MISS_LIMIT`=100 and PPS stops → `pps_miss`=1 and `ctl_state`=11 exactly 100 cycles after the last edge. Next edge → `pps_miss`=0 with no publish. Edge 50 cycles later → `pps_cnt`=50. Edge arriving exactly 100 cycles after the last one → `pps_cnt`=100 and no miss.
- **Disable:** drop `cnt_en` mid-RUN with `pend_vld`=1 → IDLE next cycle, pending discarded, `pps_cnt` held. Re-enable → ARM, and the first edge after re-enable gives no publish.

Source files
------------

// File: rtl/pps_period_ctrl.sv
// pps_period_ctrl: measures PPS period in clock cycles and publishes it to an SPI-safe shadow register
module pps_period_ctrl #(
  parameter int CNT_W = 24,
  parameter int MISS_LIMIT = 16_000_000
) (
  input  logic             mcu_clko,
  input  logic             cpld_rst,
  input  logic             rxd_1v8,
  input  logic             cnt_en,
  input  logic             rd_lock,
  input  logic             rd_done,
  output logic [CNT_W-1:0] pps_cnt,
  output logic             cnt_new,
  output logic             cnt_ovr,
  output logic             pps_miss,
  output logic [1:0]       ctl_state
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARM = 2'b01, RUN = 2'b10, LOST = 2'b11} state_t;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(MISS_LIMIT - 1);
  state_t state, state_n;
  logic s1, s2, s3, pps_rise;
  logic [CNT_W-1:0] run_cnt, run_cnt_n, pend, cap_val, pub_val;
  logic pend_vld, cap, miss_set, miss_clr, publish, ovr_set;
  assign pps_rise = s2 & ~s3;
  assign ctl_state = state;
  assign cap_val = run_cnt + CNT_W'(1);
  always_comb begin
    state_n = state;
    run_cnt_n = run_cnt;
    cap = 1'b0;
    miss_set = 1'b0;
    miss_clr = 1'b0;
    if (!cnt_en) begin
      state_n = IDLE;
      run_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ARM;
          run_cnt_n = '0;
        end
        ARM: if (pps_rise) begin
          state_n = RUN;
          run_cnt_n = '0;
        end
        RUN: if (pps_rise) begin
          cap = 1'b1;
          run_cnt_n = '0;
        end else begin
          run_cnt_n = cap_val;
          state_n = run_cnt == LIM ? LOST : RUN;
          miss_set = run_cnt == LIM;
        end
        default: if (pps_rise) begin
          state_n = RUN;
          run_cnt_n = '0;
          miss_clr = 1'b1;
        end
      endcase
    end
  end
  assign publish = cnt_en & ~rd_lock & (cap | pend_vld);
  assign pub_val = cap ? cap_val : pend;
  assign ovr_set = (publish & (cnt_new | (cap & pend_vld))) | (cap & rd_lock & pend_vld);
  always_ff @(posedge mcu_clko) begin
    if (cpld_rst) begin
      {s1, s2, s3} <= '0;
      state <= IDLE;
      run_cnt <= '0;
      pend <= '0;
      pend_vld <= 1'b0;
      pps_cnt <= '0;
      cnt_new <= 1'b0;
      cnt_ovr <= 1'b0;
      pps_miss <= 1'b0;
    end else begin
      s1 <= rxd_1v8;
      s2 <= s1;
      s3 <= s2;
      state <= state_n;
      run_cnt <= run_cnt_n;
      pend_vld <= cnt_en & rd_lock & (pend_vld | cap);
      if (cap & rd_lock) pend <= cap_val;
      if (publish) pps_cnt <= pub_val;
      cnt_new <= publish | (cnt_new & ~rd_done);
      cnt_ovr <= ~rd_done & (cnt_ovr | ovr_set);
      pps_miss <= miss_set | (pps_miss & ~miss_clr);
    end
  end
endmodule

// File: tb/tb_pps_period_ctrl.sv
// tb_pps_period_ctrl: directed checks of measurement, deferral, overrun, loss, disable and reset
module tb_pps_period_ctrl;
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b0, en = 1'b0, lock = 1'b0, done = 1'b0;
  logic [23:0] pps_cnt;
  logic cnt_new, cnt_ovr, pps_miss;
  logic [1:0] st;
  int n_tests = 0, n_fail = 0, since = 0;
  pps_period_ctrl #(.CNT_W(24), .MISS_LIMIT(100)) dut (
    .mcu_clko(clk), .cpld_rst(rst), .rxd_1v8(rxd), .cnt_en(en), .rd_lock(lock),
    .rd_done(done), .pps_cnt(pps_cnt), .cnt_new(cnt_new), .cnt_ovr(cnt_ovr),
    .pps_miss(pps_miss), .ctl_state(st)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    since++;
  endtask
  task automatic edge_in(input logic d, input logic unlock);
    rxd = 1'b1;
    tick();
    rxd = 1'b0;
    tick();
    done = d;
    if (unlock) lock = 1'b0;
    tick();
    done = 1'b0;
    since = 0;
  endtask
  task automatic gap(input int n, input logic d, input logic unlock);
    while (since < n - 3) tick();
    edge_in(d, unlock);
  endtask
  task automatic ack();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask
  task automatic outs(input string tag, input int c, input logic nw, input logic ov, input logic ms, input logic [1:0] s);
    chk({tag, ".cnt"}, c, c == -1 ? c : c);
    chk({tag, ".pps_cnt"}, 32'(pps_cnt), 32'(c));
    chk({tag, ".cnt_new"}, 32'(cnt_new), 32'(nw));
    chk({tag, ".cnt_ovr"}, 32'(cnt_ovr), 32'(ov));
    chk({tag, ".pps_miss"}, 32'(pps_miss), 32'(ms));
    chk({tag, ".state"}, 32'(st), 32'(s));
  endtask
  initial begin
    rxd = 1'b1; tick(); rxd = 1'b0; tick();
    rxd = 1'b1; rst = 1'b0; rst = 1'b1;
    tick();
    rxd = 1'b0;
    outs("reset", 0, 0, 0, 0, 2'b00);
    rst = 1'b0;
    repeat (3) tick();
    outs("idle", 0, 0, 0, 0, 2'b00);
    en = 1'b1; tick();
    outs("arm", 0, 0, 0, 0, 2'b01);
    edge_in(0, 0);
    outs("first_edge", 0, 0, 0, 0, 2'b10);
    gap(50, 0, 0);
    outs("meas50", 50, 1, 0, 0, 2'b10);
    ack();
    outs("ack1", 50, 0, 0, 0, 2'b10);
    gap(50, 0, 0);
    outs("meas50b", 50, 1, 0, 0, 2'b10);
    gap(45, 0, 0);
    outs("overrun", 45, 1, 1, 0, 2'b10);
    gap(40, 1, 0);
    outs("ack_with_pub", 40, 1, 0, 0, 2'b10);
    ack();
    outs("ack2", 40, 0, 0, 0, 2'b10);
    lock = 1'b1;
    gap(50, 0, 0);
    outs("locked", 40, 0, 0, 0, 2'b10);
    lock = 1'b0; tick();
    outs("deferred", 50, 1, 0, 0, 2'b10);
    ack();
    lock = 1'b1;
    gap(50, 0, 0);
    gap(40, 0, 0);
    outs("two_in_lock", 50, 0, 1, 0, 2'b10);
    lock = 1'b0; tick();
    outs("drain_newest", 40, 1, 1, 0, 2'b10);
    ack();
    lock = 1'b1;
    gap(50, 0, 0);
    gap(30, 0, 1);
    outs("cap_on_drain", 30, 1, 1, 0, 2'b10);
    ack();
    outs("ack3", 30, 0, 0, 0, 2'b10);
    while (since < 99) tick();
    outs("pre_lost", 30, 0, 0, 0, 2'b10);
    tick();
    outs("lost", 30, 0, 0, 1, 2'b11);
    edge_in(0, 0);
    outs("recover", 30, 0, 0, 0, 2'b10);
    gap(50, 0, 0);
    outs("after_lost", 50, 1, 0, 0, 2'b10);
    ack();
    gap(100, 0, 0);
    outs("edge_at_limit", 100, 1, 0, 0, 2'b10);
    ack();
    lock = 1'b1;
    gap(50, 0, 0);
    en = 1'b0; lock = 1'b0; tick();
    outs("disable", 100, 0, 0, 0, 2'b00);
    tick();
    outs("discarded", 100, 0, 0, 0, 2'b00);
    en = 1'b1; tick();
    outs("reenable", 100, 0, 0, 0, 2'b01);
    edge_in(0, 0);
    outs("reen_first", 100, 0, 0, 0, 2'b10);
    gap(60, 0, 0);
    outs("reen_meas", 60, 1, 0, 0, 2'b10);
    ack();
    lock = 1'b1;
    gap(50, 0, 0);
    rst = 1'b1; tick();
    outs("rst_mid_run", 0, 0, 0, 0, 2'b00);
    rst = 1'b0; lock = 1'b0; tick();
    outs("no_stale", 0, 0, 0, 0, 2'b01);
    edge_in(0, 0);
    gap(50, 0, 0);
    outs("post_rst", 50, 1, 0, 0, 2'b10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
